// File: rtl/stat_frame_collector.sv
// stat_frame_collector
//   Collects four 4-bit numbers into a frame (num1 oldest .. num4 newest),
//   captures the op code that arrives with the 4th number, and presents the
//   frame until it is acknowledged or flushed.
//
//   Ports:
//     clk, rst_n        rising-edge clock, asynchronous active-low reset
//     in_valid/in_data  upstream number stream; in_ready is the handshake back
//     op_in             op code, sampled with the 4th number of a frame
//     flush             synchronous abort of a partial or presented frame
//     frame_ack         downstream consumed the presented frame
//     num1..num4,op_out frame contents
//     frame_valid       frame complete and stable
//     fill_count        numbers currently held (0..4)
//     frame_count       completed frames since reset (wraps at 256)
//
//   Build option: STAT_SLIDING_WINDOW_EN
//     defined   - an ack keeps the newest three numbers, so each further
//                 number completes a new overlapping frame
//     undefined - an ack empties the window (non-overlapping frames)
module stat_frame_collector (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    input  logic [3:0] op_in,
    input  logic       flush,
    input  logic       frame_ack,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic [3:0] op_out,
    output logic       frame_valid,
    output logic [2:0] fill_count,
    output logic [7:0] frame_count
);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t state_q, state_d;
    logic   accept;
    logic   last_num;

`ifdef STAT_SLIDING_WINDOW_EN
    localparam logic [2:0] ACK_FILL = 3'd3;
`else
    localparam logic [2:0] ACK_FILL = 3'd0;
`endif

    // rst_n is folded in so in_ready drops immediately when reset asserts,
    // not just at the next edge.
    assign in_ready    = rst_n && (state_q == FILL);
    assign accept      = in_valid && in_ready;
    assign last_num    = accept && (fill_count == 3'd3);
    assign frame_valid = (state_q == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL:    if (last_num)  state_d = HOLD;
                HOLD:    if (frame_ack) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num1        <= '0;
            num2        <= '0;
            num3        <= '0;
            num4        <= '0;
            op_out      <= '0;
            fill_count  <= '0;
            frame_count <= '0;
        end else if (flush) begin
            // frame_count deliberately survives a flush
            num1       <= '0;
            num2       <= '0;
            num3       <= '0;
            num4       <= '0;
            op_out     <= '0;
            fill_count <= '0;
        end else if (accept) begin
            num1       <= num2;
            num2       <= num3;
            num3       <= num4;
            num4       <= in_data;
            fill_count <= fill_count + 3'd1;
            if (last_num) begin
                op_out      <= op_in;
                frame_count <= frame_count + 8'd1;
            end
        end else if (state_q == HOLD && frame_ack) begin
            fill_count <= ACK_FILL;
        end
    end

endmodule

// File: tb/tb_stat_frame_collector.sv
module tb_stat_frame_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] op_in;
    logic       flush;
    logic       frame_ack;
    logic [3:0] num1, num2, num3, num4, op_out;
    logic       frame_valid;
    logic [2:0] fill_count;
    logic [7:0] frame_count;

    int tests = 0;
    int fails = 0;
    int exp_fc = 0;

    stat_frame_collector dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .op_in(op_in), .flush(flush), .frame_ack(frame_ack),
        .num1(num1), .num2(num2), .num3(num3), .num4(num4), .op_out(op_out),
        .frame_valid(frame_valid), .fill_count(fill_count), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic [3:0] op);
        in_valid = 1'b1;
        in_data  = d;
        op_in    = op;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input logic [3:0] a, b, c, d);
        chk({tag, ".num1"}, 32'(num1), 32'(a));
        chk({tag, ".num2"}, 32'(num2), 32'(b));
        chk({tag, ".num3"}, 32'(num3), 32'(c));
        chk({tag, ".num4"}, 32'(num4), 32'(d));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; op_in = '0;
        flush = 1'b0; frame_ack = 1'b0;
        #2;
        chk("rst.in_ready",    32'(in_ready),    0);
        chk("rst.fill",        32'(fill_count),  0);
        chk("rst.frame_count", 32'(frame_count), 0);
        chk("rst.frame_valid", 32'(frame_valid), 0);
        #21 rst_n = 1'b1;
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 1);

        // basic frame 3,9,1,7
        step();
        push(4'd3, 4'h0); chk("f1.fill1", 32'(fill_count), 1);
        push(4'd9, 4'h0); chk("f1.fill2", 32'(fill_count), 2);
        push(4'd1, 4'h0); chk("f1.fill3", 32'(fill_count), 3);
        chk("f1.valid_early", 32'(frame_valid), 0);
        push(4'd7, 4'b0100); exp_fc++;
        chk("f1.valid",    32'(frame_valid), 1);
        chk_frame("f1", 4'd3, 4'd9, 4'd1, 4'd7);
        chk("f1.op",       32'(op_out),      4);
        chk("f1.fc",       32'(frame_count), 32'(exp_fc));
        chk("f1.in_ready", 32'(in_ready),    0);
        chk("f1.fill4",    32'(fill_count),  4);

        // data offered during HOLD is ignored
        in_valid = 1'b1; in_data = 4'd5; op_in = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_frame("hold", 4'd3, 4'd9, 4'd1, 4'd7);
            chk("hold.op",    32'(op_out),      4);
            chk("hold.fill",  32'(fill_count),  4);
            chk("hold.valid", 32'(frame_valid), 1);
        end
        in_valid = 1'b0;
        frame_ack = 1'b1; step(); frame_ack = 1'b0;
        chk("ack.valid",    32'(frame_valid), 0);
        chk("ack.in_ready", 32'(in_ready),    1);
        chk_frame("ack", 4'd3, 4'd9, 4'd1, 4'd7);
`ifdef STAT_SLIDING_WINDOW_EN
        chk("ack.fill", 32'(fill_count), 3);
        push(4'd12, 4'h2); exp_fc++;
        chk("slide.valid", 32'(frame_valid), 1);
        chk_frame("slide", 4'd9, 4'd1, 4'd7, 4'd12);
        chk("slide.fc", 32'(frame_count), 32'(exp_fc));
        flush = 1'b1; step(); flush = 1'b0;
`else
        chk("ack.fill", 32'(fill_count), 0);
`endif

        // ack in FILL is ignored; flush beats acceptance
        frame_ack = 1'b1; push(4'd2, 4'h0); frame_ack = 1'b0;
        chk("ackfill.fill", 32'(fill_count), 1);
        push(4'd6, 4'h0);
        in_valid = 1'b1; in_data = 4'd8; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush.fill", 32'(fill_count), 0);
        chk_frame("flush", 4'd0, 4'd0, 4'd0, 4'd0);
        chk("flush.op", 32'(op_out),      0);
        chk("flush.fc", 32'(frame_count), 32'(exp_fc));
        push(4'd1, 4'h0); push(4'd2, 4'h0); push(4'd3, 4'h0); push(4'd4, 4'h9);
        exp_fc++;
        chk("f2.valid", 32'(frame_valid), 1);
        chk_frame("f2", 4'd1, 4'd2, 4'd3, 4'd4);
        chk("f2.op", 32'(op_out),      9);
        chk("f2.fc", 32'(frame_count), 32'(exp_fc));

        // flush in HOLD drops the frame but keeps frame_count
        flush = 1'b1; step(); flush = 1'b0;
        chk("hflush.valid", 32'(frame_valid), 0);
        chk("hflush.num4",  32'(num4),        0);
        chk("hflush.fc",    32'(frame_count), 32'(exp_fc));
        chk("hflush.ready", 32'(in_ready),    1);

        // async reset mid-HOLD
        push(4'd5, 4'h0); push(4'd6, 4'h0); push(4'd7, 4'h0); push(4'd8, 4'h3);
        chk("pre_arst.valid", 32'(frame_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(frame_valid), 0);
        chk("arst.fc",    32'(frame_count), 0);
        chk("arst.fill",  32'(fill_count),  0);
        chk("arst.op",    32'(op_out),      0);
        chk("arst.ready", 32'(in_ready),    0);
        chk_frame("arst", 4'd0, 4'd0, 4'd0, 4'd0);
        #3 rst_n = 1'b1;

        // 256 frames -> frame_count wraps to 0
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 4; k++) push(4'(k + f), 4'(f));
            if (f == 254) chk("wrap.fc255", 32'(frame_count), 255);
            flush = 1'b1; step(); flush = 1'b0;
        end
        chk("wrap.fc0", 32'(frame_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stat_frame_collector.md
STAT_FRAME_COLLECTOR -- requirements
Module: stat_frame_collector

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 The block SHALL have these ports, one per line:
- in_valid  input  1  upstream number valid
- in_data  input  4  unsigned number
- in_ready  output  1  collector can accept in_data
- op_in  input  4  operation code, sampled with the 4th number of a frame
- flush  input  1  synchronous abort of the partial or held frame
- frame_ack  input  1  downstream consumed the presented frame
- num1, num2, num3, num4  output  4 each  frame numbers in arrival order, num1 oldest
- op_out  output  4  op code captured for the frame
- frame_valid  output  1  frame complete and stable
- fill_count  output  3  numbers currently held, 0..4
- frame_count  output  8  completed frames since reset, wraps 255->0

Function
REQ-003 The block SHALL implement two states: FILL (collecting) and HOLD (frame presented).
REQ-004 In FILL, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0.
REQ-005 A number SHALL be accepted only on a rising clk edge with in_valid=1 and in_ready=1.
REQ-006 On acceptance, the register slots SHALL shift: num1<=num2, num2<=num3, num3<=num4, num4<=in_data; fill_count SHALL increment by 1.
REQ-007 On the acceptance that brings fill_count to 4, op_out SHALL capture op_in, the state SHALL become HOLD, frame_valid SHALL be 1 from the next cycle (latency 1 clk), and frame_count SHALL increment modulo 256.
REQ-008 In HOLD, num1..num4, op_out and fill_count SHALL stay constant until frame_ack or flush.
REQ-009 frame_ack=1 in HOLD SHALL return the state to FILL and deassert frame_valid on the next edge; fill_count SHALL become 0, or 3 in sliding mode (REQ-016); num1..num4 SHALL keep their values.
REQ-010 frame_ack SHALL be ignored in FILL.
REQ-011 flush=1 SHALL, on the next edge, clear fill_count, num1..num4, op_out and frame_valid, and force FILL. flush SHALL have priority over acceptance and frame_ack. frame_count SHALL be unaffected.
REQ-012 in_data presented while in_ready=0 SHALL be ignored; upstream SHALL hold it.
REQ-013 fill_count SHALL never exceed 4 or underflow.

Reset
REQ-014 While rst_n=0, the block SHALL immediately set state=FILL, num1..num4=0, op_out=0, frame_valid=0, fill_count=0, frame_count=0 and in_ready=0.
REQ-015 in_ready SHALL become 1 in the first cycle after rst_n deasserts. A reset during HOLD or a partial fill SHALL discard the frame without asserting frame_valid.

Configuration
REQ-016 Macro STAT_SLIDING_WINDOW_EN:
- Defined: frame_ack SHALL set fill_count to 3, keeping num2..num4 as the next frame's oldest three, so each further accepted number completes a new frame.
- Undefined: frame_ack SHALL set fill_count to 0, giving non-overlapping frames of 4 numbers.
- Flush and reset behave identically in both builds.

Verification
REQ-017 Reset, then send 3,9,1,7 with in_valid=1 on consecutive cycles and op_in=4'b0100 on the 4th -> frame_valid=1 the cycle after the 4th; num1..4=3,9,1,7; op_out=0100; frame_count=1; in_ready=0.
REQ-018 Hold in_valid=1 with in_data=5 during HOLD for 3 cycles, then frame_ack -> outputs unchanged during HOLD; frame_valid=0 and in_ready=1 next cycle; fill_count=0 (macro off) or 3 (macro on).
REQ-019 Macro on: after REQ-017 and ack, send 12 -> new frame 9,1,7,12 valid the next cycle; frame_count=2.
REQ-020 Send 2,6, then flush=1 together with in_valid=1 and in_data=8 -> fill_count=0, num1..4=0, in_data ignored; next 4 numbers form a clean frame.
REQ-021 Pull rst_n low mid-HOLD, asynchronous to clk -> all outputs 0 immediately; 256 completed frames from reset -> frame_count wraps to 0.
